// File: rtl/i2c_codec_responder.sv
// rtl/i2c_codec_responder.sv - I2C write-only target for 24-bit codec configuration frames
module i2c_codec_responder #(
    parameter logic [6:0] DEV_ADDR = 7'h1A
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        I2C_SCLK,
    inout  wire         I2C_SDAT,
    output logic [15:0] DATA,
    output logic        VALID,
    output logic        ERR,
    output logic        BUSY,
    output logic [3:0]  BIT_CNT
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_BYTE,
        S_BYTE_ACK,
        S_WAIT_STOP
    } state_t;

    // Bus synchronizers; idle-high reset so a reset never fabricates a START.
    logic r_scl_s1, r_scl_s2, r_scl_prev;
    logic r_sda_s1, r_sda_s2, r_sda_prev;

    state_t      r_state, w_state_nxt;
    // Only seven history bits are kept; the eighth bit is the live sample.
    logic [6:0]  r_shift, w_shift_nxt;
    logic [3:0]  r_bit_cnt, w_bit_cnt_nxt;
    logic [1:0]  r_byte_cnt, w_byte_cnt_nxt;
    logic [7:0]  r_reg_byte, w_reg_byte_nxt;
    logic [7:0]  r_data_byte, w_data_byte_nxt;
    logic        r_ovf, w_ovf_nxt;
    logic        r_busy, w_busy_nxt;
    logic        r_ack_drv, w_ack_drv_nxt;
    logic [15:0] r_data, w_data_nxt;
    logic        r_valid, w_valid_nxt;
    logic        r_err, w_err_nxt;

    logic       w_scl_rise, w_scl_fall, w_start, w_stop;
    logic [7:0] w_byte;

    assign w_scl_rise = r_scl_s2 & ~r_scl_prev;
    assign w_scl_fall = ~r_scl_s2 & r_scl_prev;
    assign w_start    = r_scl_s2 & r_scl_prev & r_sda_prev & ~r_sda_s2;
    assign w_stop     = r_scl_s2 & r_scl_prev & ~r_sda_prev & r_sda_s2;
    assign w_byte     = {r_shift, r_sda_s2};

    // Open drain: only ever pull low or release.
    assign I2C_SDAT = r_ack_drv ? 1'b0 : 1'bz;

    assign DATA    = r_data;
    assign VALID   = r_valid;
    assign ERR     = r_err;
    assign BUSY    = r_busy;
    assign BIT_CNT = r_bit_cnt;

    // Two-flop synchronizers plus previous-value registers for edge detection.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_scl_s1   <= 1'b1;
            r_scl_s2   <= 1'b1;
            r_scl_prev <= 1'b1;
            r_sda_s1   <= 1'b1;
            r_sda_s2   <= 1'b1;
            r_sda_prev <= 1'b1;
        end else begin
            r_scl_s1   <= I2C_SCLK;
            r_scl_s2   <= r_scl_s1;
            r_scl_prev <= r_scl_s2;
            r_sda_s1   <= I2C_SDAT;
            r_sda_s2   <= r_sda_s1;
            r_sda_prev <= r_sda_s2;
        end
    end

    // Frame state register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_byte_cnt  <= '0;
            r_reg_byte  <= '0;
            r_data_byte <= '0;
            r_ovf       <= 1'b0;
            r_busy      <= 1'b0;
            r_ack_drv   <= 1'b0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_shift     <= w_shift_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_byte_cnt  <= w_byte_cnt_nxt;
            r_reg_byte  <= w_reg_byte_nxt;
            r_data_byte <= w_data_byte_nxt;
            r_ovf       <= w_ovf_nxt;
            r_busy      <= w_busy_nxt;
            r_ack_drv   <= w_ack_drv_nxt;
            r_data      <= w_data_nxt;
            r_valid     <= w_valid_nxt;
            r_err       <= w_err_nxt;
        end
    end

    // Next-state logic; START/STOP override whatever the frame was doing.
    always_comb begin
        w_state_nxt     = r_state;
        w_shift_nxt     = r_shift;
        w_bit_cnt_nxt   = r_bit_cnt;
        w_byte_cnt_nxt  = r_byte_cnt;
        w_reg_byte_nxt  = r_reg_byte;
        w_data_byte_nxt = r_data_byte;
        w_ovf_nxt       = r_ovf;
        w_busy_nxt      = r_busy;
        w_ack_drv_nxt   = r_ack_drv;
        w_data_nxt      = r_data;
        w_valid_nxt     = 1'b0;
        w_err_nxt       = 1'b0;

        if (w_start) begin
            // A repeated START abandons an addressed frame in flight.
            w_err_nxt      = r_busy;
            w_state_nxt    = S_ADDR;
            w_bit_cnt_nxt  = '0;
            w_byte_cnt_nxt = '0;
            w_ovf_nxt      = 1'b0;
            w_busy_nxt     = 1'b0;
            w_ack_drv_nxt  = 1'b0;
        end else if (w_stop) begin
            if (r_busy) begin
                if (r_byte_cnt == 2'd2 && !r_ovf) begin
                    w_valid_nxt = 1'b1;
                    w_data_nxt  = {r_reg_byte, r_data_byte};
                end else begin
                    w_err_nxt = 1'b1;
                end
            end
            w_state_nxt   = S_IDLE;
            w_bit_cnt_nxt = '0;
            w_busy_nxt    = 1'b0;
            w_ack_drv_nxt = 1'b0;
        end else begin
            case (r_state)
                S_ADDR: begin
                    if (w_scl_rise) begin
                        w_shift_nxt   = w_byte[6:0];
                        w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                        if (r_bit_cnt == 4'd7) begin
                            if (w_byte == {DEV_ADDR, 1'b0}) begin
                                w_state_nxt = S_ADDR_ACK;
                                w_busy_nxt  = 1'b1;
                            end else begin
                                w_state_nxt = S_WAIT_STOP;
                            end
                        end
                    end
                end
                S_ADDR_ACK, S_BYTE_ACK: begin
                    // First SCL fall starts the ACK bit, the second ends it.
                    if (w_scl_fall) begin
                        if (!r_ack_drv) begin
                            w_ack_drv_nxt = 1'b1;
                        end else begin
                            w_ack_drv_nxt = 1'b0;
                            w_state_nxt   = S_BYTE;
                            w_bit_cnt_nxt = '0;
                        end
                    end
                end
                S_BYTE: begin
                    if (w_scl_rise) begin
                        w_shift_nxt   = w_byte[6:0];
                        w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                        if (r_bit_cnt == 4'd7) begin
                            if (r_byte_cnt == 2'd0) begin
                                w_reg_byte_nxt = w_byte;
                                w_byte_cnt_nxt = 2'd1;
                                w_state_nxt    = S_BYTE_ACK;
                            end else if (r_byte_cnt == 2'd1) begin
                                w_data_byte_nxt = w_byte;
                                w_byte_cnt_nxt  = 2'd2;
                                w_state_nxt     = S_BYTE_ACK;
                            end else begin
                                w_ovf_nxt   = 1'b1;
                                w_state_nxt = S_WAIT_STOP;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_codec_responder.sv
// tb/tb_i2c_codec_responder.sv - self-checking bench for i2c_codec_responder
module tb_i2c_codec_responder;

    localparam int Q = 6;
    localparam int H = 12;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        scl = 1'b1;
    logic        m_sda_low = 1'b0;
    wire         sda;
    logic [15:0] data;
    logic        valid, err, busy;
    logic [3:0]  bit_cnt;

    assign sda = m_sda_low ? 1'b0 : 1'bz;
    pullup (sda);

    i2c_codec_responder dut (
        .CLK      (clk),
        .RESET    (rst),
        .I2C_SCLK (scl),
        .I2C_SDAT (sda),
        .DATA     (data),
        .VALID    (valid),
        .ERR      (err),
        .BUSY     (busy),
        .BIT_CNT  (bit_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Frame-level model state (owned by the stimulus process)
    int          exp_valid = 0;
    int          exp_err = 0;
    logic [15:0] m_pending_data = 16'h0000;
    logic        m_open_addressed = 1'b0;
    logic        m_addressed = 1'b0;
    logic        m_tracking = 1'b0;
    int          m_nbytes = 0;
    logic [7:0]  m_reg = 8'h00;
    logic [7:0]  m_dat = 8'h00;
    logic        ack_allow = 1'b0;

    // Observation state (owned by the compare process)
    int          obs_valid = 0;
    int          obs_err = 0;
    logic [15:0] m_data_cur = 16'h0000;
    logic        valid_q = 1'b0;
    logic        err_q = 1'b0;
    logic        rst_q = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) rst_q <= rst;

    // Per-cycle compare against the frame-level model
    always @(negedge clk) begin
        if (rst_q) begin
            chk("rst_data", data, 0);
            chk("rst_valid", valid, 0);
            chk("rst_err", err, 0);
            chk("rst_busy", busy, 0);
            chk("rst_bitcnt", bit_cnt, 0);
            m_data_cur = 16'h0000;
            valid_q = 1'b0;
            err_q = 1'b0;
        end else begin
            if (valid || err) chk("valid_err_exclusive", valid & err, 0);
            if (valid) begin
                chk("valid_data", data, m_pending_data);
                chk("valid_width", valid_q, 0);
                m_data_cur = m_pending_data;
                obs_valid++;
            end else begin
                chk("data_hold", data, m_data_cur);
            end
            if (err) begin
                chk("err_width", err_q, 0);
                obs_err++;
            end
            valid_q = valid;
            err_q = err;
        end
        if (!m_sda_low && !ack_allow) chk("sda_released", sda === 1'b0, 0);
    end

    task automatic ticks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic i2c_start();
        if (m_open_addressed) exp_err++;
        m_sda_low = 1'b0;
        ticks(Q);
        scl = 1'b1;
        ticks(H);
        m_sda_low = 1'b1;
        ticks(H);
        scl = 1'b0;
        ticks(Q);
        m_open_addressed = 1'b0;
        m_addressed = 1'b0;
        m_tracking = 1'b1;
        m_nbytes = 0;
    endtask

    task automatic i2c_stop();
        m_sda_low = 1'b1;
        ticks(Q);
        scl = 1'b1;
        ticks(H);
        if (m_open_addressed) begin
            if (m_nbytes == 3) begin
                exp_valid++;
                m_pending_data = {m_reg, m_dat};
            end else begin
                exp_err++;
            end
        end
        m_sda_low = 1'b0;
        ticks(2 * H);
        m_open_addressed = 1'b0;
        m_tracking = 1'b0;
        chk("busy_after_stop", busy, 0);
        chk("valid_count", obs_valid, exp_valid);
        chk("err_count", obs_err, exp_err);
    endtask

    task automatic write_byte(input logic [7:0] b, input int rst_bit);
        int   idx;
        logic exp_ack;
        logic tracking_now;
        idx = m_nbytes;
        if (idx == 0) begin
            exp_ack = m_tracking && (b == 8'h34);
            tracking_now = m_tracking;
        end else begin
            exp_ack = m_tracking && m_addressed && (idx <= 2);
            tracking_now = exp_ack;
        end
        for (int i = 7; i >= 0; i--) begin
            m_sda_low = ~b[i];
            if (i == rst_bit) begin
                @(posedge clk); #1;
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                chk("midrst_data", data, 0);
                chk("midrst_busy", busy, 0);
                chk("midrst_bitcnt", bit_cnt, 0);
                chk("midrst_valid", valid, 0);
                m_tracking = 1'b0;
                m_addressed = 1'b0;
                m_open_addressed = 1'b0;
                exp_ack = 1'b0;
                tracking_now = 1'b0;
            end
            ticks(Q);
            scl = 1'b1;
            ticks(H);
            scl = 1'b0;
            if (i == 0) ack_allow = exp_ack;
            ticks(Q);
            if (i == 4 && tracking_now) chk("bitcnt_mid", bit_cnt, 4);
        end
        m_sda_low = 1'b0;
        ticks(Q);
        scl = 1'b1;
        ticks(H / 2);
        chk("ack", sda === 1'b0, exp_ack);
        if (exp_ack) chk("bitcnt_full", bit_cnt, 8);
        if (idx == 0 && m_tracking) chk("busy_after_addr", busy, exp_ack);
        ticks(H / 2);
        scl = 1'b0;
        ticks(Q);
        ack_allow = 1'b0;
        if (idx == 0) begin
            m_addressed = exp_ack;
            m_open_addressed = exp_ack;
        end
        if (exp_ack && idx == 1) m_reg = b;
        if (exp_ack && idx == 2) m_dat = b;
        if (!exp_ack) m_tracking = 1'b0;
        m_nbytes++;
    endtask

    task automatic frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                         input logic [7:0] b3, input int n, input bit do_stop,
                         input int rst_byte, input int rst_bit);
        logic [7:0] bytes [4];
        bytes[0] = b0;
        bytes[1] = b1;
        bytes[2] = b2;
        bytes[3] = b3;
        i2c_start();
        for (int k = 0; k < n; k++) write_byte(bytes[k], (k == rst_byte) ? rst_bit : -1);
        if (do_stop) i2c_stop();
    endtask

    initial begin
        ticks(4);
        rst = 1'b0;
        ticks(2);
        chk("reset_data", data, 16'h0000);
        chk("reset_busy", busy, 0);
        chk("reset_bitcnt", bit_cnt, 0);
        chk("reset_sda", sda === 1'b1, 1);

        // Good write
        frame(8'h34, 8'h1E, 8'h00, 8'h00, 3, 1'b1, -1, -1);
        chk("lit_1e00", data, 16'h1E00);
        chk("lit_valid_cnt1", obs_valid, 1);

        // Wrong address: ignored entirely
        frame(8'h36, 8'h11, 8'h22, 8'h00, 3, 1'b1, -1, -1);
        chk("lit_wrong_addr_data", data, 16'h1E00);
        chk("lit_wrong_addr_err", obs_err, 0);

        // Read address, then repeated START into a good frame
        frame(8'h35, 8'h00, 8'h00, 8'h00, 1, 1'b0, -1, -1);
        frame(8'h34, 8'h04, 8'h15, 8'h00, 3, 1'b1, -1, -1);
        chk("lit_0415", data, 16'h0415);
        chk("lit_err_cnt0", obs_err, 0);

        // Overflow: fourth byte NACKed, ERR, DATA kept
        frame(8'h34, 8'h02, 8'h79, 8'hAA, 4, 1'b1, -1, -1);
        chk("lit_ovf_data", data, 16'h0415);
        chk("lit_err_cnt1", obs_err, 1);

        // Repeated START inside an addressed frame
        frame(8'h34, 8'h08, 8'h00, 8'h00, 2, 1'b0, -1, -1);
        frame(8'h34, 8'h08, 8'h12, 8'h00, 3, 1'b1, -1, -1);
        chk("lit_0812", data, 16'h0812);
        chk("lit_err_cnt2", obs_err, 2);

        // RESET during the register byte
        frame(8'h34, 8'h1E, 8'h00, 8'h00, 3, 1'b1, 1, 4);
        chk("lit_rst_data", data, 16'h0000);
        chk("lit_rst_valid_cnt", obs_valid, 3);

        // Normal operation resumes
        frame(8'h34, 8'h5A, 8'hA5, 8'h00, 3, 1'b1, -1, -1);
        chk("lit_5aa5", data, 16'h5AA5);
        chk("lit_final_valid", obs_valid, 4);
        chk("lit_final_err", obs_err, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
